// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// Optional memory wait states: define CTRL_MEM_WAIT_EN.
module multicycle_ctrl #(
  parameter int OPC_WIDTH   = 6,
  parameter int STATE_WIDTH = 4
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [OPC_WIDTH-1:0]   Opcode,
  input  logic                   Zero,
`ifdef CTRL_MEM_WAIT_EN
  input  logic                   MemReady,
`endif
  output logic                   PCEn,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             PCSource,
  output logic                   InstrDone,
  output logic                   IllegalOp,
  output logic [STATE_WIDTH-1:0] State
);

  typedef enum logic [STATE_WIDTH-1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_RWB,
    S_BRANCH,
    S_JUMP,
    S_ADDIEX,
    S_ADDIWB
  } state_e;

  localparam logic [OPC_WIDTH-1:0] OP_R    = OPC_WIDTH'(6'b000000);
  localparam logic [OPC_WIDTH-1:0] OP_J    = OPC_WIDTH'(6'b000010);
  localparam logic [OPC_WIDTH-1:0] OP_BEQ  = OPC_WIDTH'(6'b000100);
  localparam logic [OPC_WIDTH-1:0] OP_ADDI = OPC_WIDTH'(6'b001000);
  localparam logic [OPC_WIDTH-1:0] OP_LW   = OPC_WIDTH'(6'b100011);
  localparam logic [OPC_WIDTH-1:0] OP_SW   = OPC_WIDTH'(6'b101011);

  state_e               state_q, state_d;
  logic [OPC_WIDTH-1:0] opc_q, opc_d;
  logic                 mem_rdy;
  logic                 op_mem, op_r, op_beq, op_j, op_addi, op_ok;
  logic                 pc_write, pc_write_cond;

`ifdef CTRL_MEM_WAIT_EN
  assign mem_rdy = MemReady;
`else
  assign mem_rdy = 1'b1;
`endif

  assign op_mem  = (Opcode == OP_LW) || (Opcode == OP_SW);
  assign op_r    = (Opcode == OP_R);
  assign op_beq  = (Opcode == OP_BEQ);
  assign op_j    = (Opcode == OP_J);
  assign op_addi = (Opcode == OP_ADDI);
  assign op_ok   = op_mem | op_r | op_beq | op_j | op_addi;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        opc_d = Opcode;
        unique case (1'b1)
          op_mem:  state_d = S_MEMADR;
          op_r:    state_d = S_EXEC;
          op_beq:  state_d = S_BRANCH;
          op_j:    state_d = S_JUMP;
          op_addi: state_d = S_ADDIEX;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opc_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // Moore decode; only FETCH/MEMWR strobes see MemReady in wait builds
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;
    InstrDone     = 1'b0;
    IllegalOp     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        IRWrite  = mem_rdy;
        ALUSrcB  = 2'b01;
        pc_write = mem_rdy;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        IllegalOp = !op_ok;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = mem_rdy;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        PCSource      = 2'b01;
        InstrDone     = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        PCSource  = 2'b10;
        InstrDone = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCEn  = pc_write | (pc_write_cond & Zero);
  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a path/control-table model.
// Define CTRL_MEM_WAIT_EN to exercise memory wait states.
module tb_multicycle_ctrl;

  localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3;
  localparam int MEMRD = 4, MEMWB = 5, MEMWR = 6, EXEC = 7;
  localparam int RWB = 8, BRANCH = 9, JUMP = 10, ADDIEX = 11;
  localparam int ADDIWB = 12 - 0 - 0;

`ifdef CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [5:0] OR_ = 6'b000000, OJ = 6'b000010;
  localparam logic [5:0] OBEQ = 6'b000100, OADDI = 6'b001000;
  localparam logic [5:0] OLW = 6'b100011, OSW = 6'b101011;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rwr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       done;
    logic       ill;
  } ctl_t;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       rdy;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       InstrDone, IllegalOp;
  logic [3:0] State;
  ctl_t       act;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 Clk = ~Clk;

  multicycle_ctrl dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Opcode   (Opcode),
    .Zero     (Zero),
`ifdef CTRL_MEM_WAIT_EN
    .MemReady (rdy),
`endif
    .PCEn     (PCEn),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .MemtoReg (MemtoReg),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .PCSource (PCSource),
    .InstrDone(InstrDone),
    .IllegalOp(IllegalOp),
    .State    (State)
  );

  assign act = {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                InstrDone, IllegalOp};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o == OR_ || o == OJ || o == OBEQ || o == OADDI ||
           o == OLW || o == OSW;
  endfunction

  // Control table for each state, straight from the state list
  function automatic ctl_t exp_ctl(input int s, input logic z,
                                   input logic r, input logic ill);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = r; c.pcen = r; end
      DECODE: begin c.srcb = 2'b11; c.ill = ill; end
      MEMADR: begin c.srca = 1; c.srcb = 2'b10; end
      MEMRD:  begin c.mrd = 1; c.iord = 1; end
      MEMWB:  begin c.rwr = 1; c.m2r = 1; c.done = 1; end
      MEMWR:  begin c.mwr = 1; c.iord = 1; c.done = r; end
      EXEC:   begin c.srca = 1; c.aluop = 2'b10; end
      RWB:    begin c.rwr = 1; c.rdst = 1; c.done = 1; end
      BRANCH: begin
        c.srca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01;
        c.done = 1; c.pcen = z;
      end
      JUMP:   begin c.pcen = 1; c.pcsrc = 2'b10; c.done = 1; end
      ADDIEX: begin c.srca = 1; c.srcb = 2'b10; end
      ADDIWB: begin c.rwr = 1; c.done = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic cycle_chk(input int s, input logic ill);
    chk("state", 32'(State), 32'(s));
    chk("ctl", 32'(act), 32'(exp_ctl(s, Zero, rdy, ill)));
    chk("pcsrc11", 32'(PCSource == 2'b11), 32'd0);
    chk("rd_and_wr", 32'(MemRead & MemWrite), 32'd0);
  endtask

  // Starts and ends in FETCH; rd_wait < 0 picks random wait lengths
  task automatic run_instr(input logic [5:0] opc, input logic z,
                           input int rd_wait);
    int path[$];
    int nw;
    int done_n;
    int ill_n;
    bit illg;
    illg = !is_legal(opc);
    case (opc)
      OLW:   path = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
      OSW:   path = '{FETCH, DECODE, MEMADR, MEMWR};
      OR_:   path = '{FETCH, DECODE, EXEC, RWB};
      OBEQ:  path = '{FETCH, DECODE, BRANCH};
      OJ:    path = '{FETCH, DECODE, JUMP};
      OADDI: path = '{FETCH, DECODE, ADDIEX, ADDIWB};
      default: path = '{FETCH, DECODE};
    endcase
    Opcode = opc;
    Zero = z;
    done_n = 0;
    ill_n = 0;
    foreach (path[k]) begin
      nw = 0;
      if (WAIT_EN && (path[k] == FETCH || path[k] == MEMRD ||
                      path[k] == MEMWR)) begin
        if (rd_wait >= 0) nw = (path[k] == MEMRD) ? rd_wait : 0;
        else nw = $urandom_range(0, 2);
      end
      for (int w = 0; w <= nw; w++) begin
        rdy = (w == nw);
        #1;
        cycle_chk(path[k], illg && path[k] == DECODE);
        if (InstrDone) done_n++;
        if (IllegalOp) ill_n++;
        @(posedge Clk);
        #1;
      end
      if (path[k] == DECODE) Opcode = 6'($urandom);
    end
    rdy = 1'b1;
    #1;
    chk("end_fetch", 32'(State), 32'(FETCH));
    chk("done_cnt", 32'(done_n), illg ? 32'd0 : 32'd1);
    chk("ill_cnt", 32'(ill_n), illg ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [5:0] legal[6];
    logic [5:0] o;
    legal = '{OR_, OLW, OSW, OADDI, OJ, OBEQ};
    Reset_n = 1'b0;
    Opcode = '0;
    Zero = 1'b0;
    rdy = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    #1;
    chk("rst_state", 32'(State), 32'(IDLE));
    chk("rst_ctl", 32'(act), 32'd0);
    @(posedge Clk);
    #1;
    chk("fetch_state", 32'(State), 32'(FETCH));
    chk("fetch_mrd", 32'(MemRead), 32'd1);
    chk("fetch_pcen", 32'(PCEn), 32'd1);

    foreach (legal[i]) run_instr(legal[i], 1'b0, 0);
    run_instr(OBEQ, 1'b1, 0);
    run_instr(OBEQ, 1'b0, 0);
    run_instr(6'b111111, 1'b0, 0);
    if (WAIT_EN) run_instr(OLW, 1'b0, 3);

    for (int i = 0; i < 60; i++) begin
      o = legal[$urandom_range(0, 5)];
      if ($urandom_range(0, 4) == 0) begin
        o = 6'($urandom);
        if (is_legal(o)) o = 6'b111110;
      end
      run_instr(o, 1'($urandom), -1);
    end

    // reset while a store is in MEMWR
    Opcode = OSW;
    rdy = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("sw_memwr", 32'(State), 32'(MEMWR));
    chk("sw_mwr", 32'(MemWrite), 32'd1);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    chk("abort_state", 32'(State), 32'(IDLE));
    chk("abort_mwr", 32'(MemWrite), 32'd0);
    chk("abort_ctl", 32'(act), 32'd0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("abort_fetch", 32'(State), 32'(FETCH));

`ifdef CTRL_MEM_WAIT_EN
    rdy = 1'b0;
    @(posedge Clk);
    #1;
    chk("wait_hold", 32'(State), 32'(FETCH));
    chk("wait_irw", 32'(IRWrite), 32'd0);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    chk("wait_rst", 32'(State), 32'(IDLE));
    Reset_n = 1'b1;
    rdy = 1'b1;
    @(posedge Clk);
    #1;
`endif
    run_instr(OJ, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
